ft2_tx_writer: RTL and testbench

Device-to-host return path for the FT2 (FT2232 245-style async FIFO) interface. Buffers bytes from internal producers, such as I2C readback and front-end status, in a small byte FIFO. Drains them to the host by driving ft2_data and pulsing ft2_wr_n whenever ft2_txe_n permits. It shares the FT2 data bus with the existing host-to-device read engine through a request/grant pair and never drives the bus without grant.

---
 rtl/ft2_pkg.sv | 18 +
 rtl/ft2_tx_byte_fifo.sv | 55 +++++
 rtl/ft2_tx_writer.sv | 139 +++++++++++++
 tb/tb_ft2_tx_writer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft2_pkg.sv
// Shared FT2 definitions: bus width, writer FSM states and default bus timing
// used by both the host-to-device read engine and the device-to-host writer.
package ft2_pkg;
  localparam int FT2_DATA_W         = 8;
  localparam int FT2_SETUP_CYCLES   = 1;
  localparam int FT2_STROBE_CYCLES  = 2;
  localparam int FT2_RECOVER_CYCLES = 3;
  localparam int FT2_CNT_W          = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } ft2_tx_state_t;
endpackage

// File: rtl/ft2_tx_byte_fifo.sv
// Sync first-word-fall-through byte FIFO, head visible the cycle after push.
// Full pushes are dropped and latch a sticky overflow unless a pop frees the slot.
module ft2_tx_byte_fifo import ft2_pkg::*; #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [FT2_DATA_W-1:0] i_data,
  input  logic                  i_pop,
  output logic [FT2_DATA_W-1:0] o_head,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [FT2_DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;
  logic                  w_rd;
  logic                  w_wr;

  assign o_full     = (r_level == (DEPTH_LOG2+1)'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_head     = r_mem[r_rptr];
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

  // a pop in the same cycle frees the slot, so a full FIFO can still take the push
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)      r_level <= r_level + 1'b1;
      else if (w_rd && !w_wr) r_level <= r_level - 1'b1;
      if (i_push && !w_wr) r_overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/ft2_tx_writer.sv
// FT2 device-to-host writer: buffers bytes and strobes them onto the shared bus under grant,
// one byte per 1+SETUP+STROBE+1+RECOVER cycles; in_ready drops at full. FT2_TX_STATS_EN adds tx_count.
module ft2_tx_writer import ft2_pkg::*; #(
  parameter int DEPTH_LOG2     = 4,
  parameter int SETUP_CYCLES   = FT2_SETUP_CYCLES,
  parameter int STROBE_CYCLES  = FT2_STROBE_CYCLES,
  parameter int RECOVER_CYCLES = FT2_RECOVER_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FT2_DATA_W-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  ft2_txe_n,
  input  logic                  ft2_bus_gnt,
  output logic                  ft2_bus_req,
  output logic [FT2_DATA_W-1:0] ft2_data_o,
  output logic                  ft2_data_oe,
  output logic                  ft2_wr_n,
  output logic [DEPTH_LOG2:0]   fifo_level,
`ifdef FT2_TX_STATS_EN
  output logic [15:0]           tx_count,
`endif
  output logic                  overflow
);
  ft2_tx_state_t         r_state;
  logic [FT2_CNT_W-1:0]  r_cnt;
  logic                  r_txe_s1;
  logic                  r_txe_s2;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [FT2_DATA_W-1:0] w_head;

  assign in_ready = !w_full && !rst;
  assign w_pop    = (r_state == REQ) && ft2_bus_gnt;

  ft2_tx_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (in_valid),
    .i_data     (in_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_level    (fifo_level),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_overflow (overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txe_s1 <= 1'b1;
      r_txe_s2 <= 1'b1;
    end else begin
      r_txe_s1 <= ft2_txe_n;
      r_txe_s2 <= r_txe_s1;
    end
  end

`ifdef FT2_TX_STATS_EN
  logic [15:0] r_tx_count;
  assign tx_count = r_tx_count;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      ft2_bus_req <= 1'b0;
      ft2_data_o  <= '0;
      ft2_data_oe <= 1'b0;
      ft2_wr_n    <= 1'b1;
`ifdef FT2_TX_STATS_EN
      r_tx_count  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty && !r_txe_s2) begin
            r_state     <= REQ;
            ft2_bus_req <= 1'b1;
          end
        end
        REQ: begin
          if (ft2_bus_gnt) begin
            ft2_data_o  <= w_head;
            ft2_data_oe <= 1'b1;
            r_cnt       <= FT2_CNT_W'(SETUP_CYCLES - 1);
            r_state     <= SETUP;
          end else if (r_txe_s2) begin
            ft2_bus_req <= 1'b0;
            r_state     <= IDLE;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            ft2_wr_n <= 1'b0;
            r_cnt    <= FT2_CNT_W'(STROBE_CYCLES - 1);
            r_state  <= STROBE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STROBE: begin
          if (r_cnt == '0) begin
            ft2_wr_n <= 1'b1;
            r_state  <= HOLD;
`ifdef FT2_TX_STATS_EN
            r_tx_count <= r_tx_count + 16'd1;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          ft2_data_oe <= 1'b0;
          ft2_bus_req <= 1'b0;
          r_cnt       <= FT2_CNT_W'(RECOVER_CYCLES - 1);
          r_state     <= RECOVER;
        end
        RECOVER: begin
          // last recovery cycle doubles as the IDLE decision so back-to-back bytes lose no cycle
          if (r_cnt == '0) begin
            if (!w_empty && !r_txe_s2) begin
              ft2_bus_req <= 1'b1;
              r_state     <= REQ;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ft2_tx_writer.sv
// Directed bench for ft2_tx_writer: FIFO ordering, strobe timing, txe gating,
// overflow, grant handshake and asynchronous reset mid-transaction.
module tb_ft2_tx_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ft2_txe_n = 1'b1;
  logic       ft2_bus_gnt;
  logic       ft2_bus_req;
  logic [7:0] ft2_data_o;
  logic       ft2_data_oe;
  logic       ft2_wr_n;
  logic [4:0] fifo_level;
  logic       overflow;
`ifdef FT2_TX_STATS_EN
  logic [15:0] tx_count;
`endif

  logic gnt_follow = 1'b1;
  logic gnt_force  = 1'b0;
  assign ft2_bus_gnt = gnt_follow ? ft2_bus_req : gnt_force;

  ft2_tx_writer dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ft2_txe_n   (ft2_txe_n),
    .ft2_bus_gnt (ft2_bus_gnt),
    .ft2_bus_req (ft2_bus_req),
    .ft2_data_o  (ft2_data_o),
    .ft2_data_oe (ft2_data_oe),
    .ft2_wr_n    (ft2_wr_n),
    .fifo_level  (fifo_level),
`ifdef FT2_TX_STATS_EN
    .tx_count    (tx_count),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // strobe collector: start cycle, data at strobe start, low length; plus bus-rule violations
  int         st_cyc[$];
  logic [7:0] st_dat[$];
  int         st_len[$];
  logic       prev_wr_n = 1'b1;
  logic       prev_oe = 1'b0;
  logic [7:0] oe_data = '0;
  int         low_cnt = 0;
  int         stab_err = 0;
  int         bus_viol = 0;

  always @(negedge clk) begin
    if (prev_wr_n && !ft2_wr_n) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(ft2_data_o);
      low_cnt = 0;
    end
    if (!ft2_wr_n) low_cnt++;
    if (!prev_wr_n && ft2_wr_n) st_len.push_back(low_cnt);
    if (ft2_data_oe) begin
      if (!prev_oe) oe_data = ft2_data_o;
      else if (ft2_data_o !== oe_data) stab_err++;
      if (!ft2_bus_gnt) bus_viol++;
    end
    if (!ft2_wr_n && !ft2_data_oe) bus_viol++;
    prev_wr_n = ft2_wr_n;
    prev_oe   = ft2_data_oe;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clr();
    st_cyc.delete();
    st_dat.delete();
    st_len.delete();
  endtask

  task automatic push_bytes(input logic [7:0] b [$]);
    foreach (b[i]) begin
      in_data  = b[i];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_lens(input int n, input int budget);
    int k = 0;
    while (st_len.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #23;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (ft2_bus_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", ft2_bus_req); end
    total++; if (ft2_data_o !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", ft2_data_o); end
    total++; if (ft2_data_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b want=0", ft2_data_oe); end
    total++; if (ft2_wr_n !== 1'b1) begin bad++; $display("FAIL rst_wr_n got=%b want=1", ft2_wr_n); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    ft2_txe_n  = 1'b0;
    gnt_follow = 1'b1;
    tick(4);
    clr();
    push_bytes('{8'hA5, 8'h3C});
    wait_lens(2, 60);
    total++; if (st_len.size() !== 2) begin bad++; $display("FAIL basic_count got=%0d want=2", st_len.size()); end
    if (st_len.size() == 2) begin
      total++; if (st_dat[0] !== 8'hA5) begin bad++; $display("FAIL basic_b0 got=%h want=a5", st_dat[0]); end
      total++; if (st_dat[1] !== 8'h3C) begin bad++; $display("FAIL basic_b1 got=%h want=3c", st_dat[1]); end
      total++; if (st_len[0] !== 2) begin bad++; $display("FAIL basic_len0 got=%0d want=2", st_len[0]); end
      total++; if (st_len[1] !== 2) begin bad++; $display("FAIL basic_len1 got=%0d want=2", st_len[1]); end
      total++; if (st_cyc[1] - st_cyc[0] !== 8) begin bad++; $display("FAIL basic_period got=%0d want=8", st_cyc[1] - st_cyc[0]); end
    end
    tick(8);
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL basic_level got=%0d want=0", fifo_level); end
    total++; if (stab_err !== 0) begin bad++; $display("FAIL basic_stable got=%0d want=0", stab_err); end
  endtask

  task automatic test_txe_block();
    int seen = 0;
    int c0;
    ft2_txe_n = 1'b1;
    tick(4);
    clr();
    push_bytes('{8'h10, 8'h20, 8'h30});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ft2_bus_req || !ft2_wr_n) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL txe_block_activity got=%0d want=0", seen); end
    total++; if (fifo_level !== 5'd3) begin bad++; $display("FAIL txe_block_level got=%0d want=3", fifo_level); end
    ft2_txe_n = 1'b0;
    c0 = cyc;
    wait_lens(3, 60);
    total++; if (st_len.size() !== 3) begin bad++; $display("FAIL txe_count got=%0d want=3", st_len.size()); end
    if (st_len.size() == 3) begin
      total++; if (st_cyc[0] - c0 < 5) begin bad++; $display("FAIL txe_latency got=%0d want>=5", st_cyc[0] - c0); end
      total++; if (st_dat[0] !== 8'h10 || st_dat[1] !== 8'h20 || st_dat[2] !== 8'h30) begin
        bad++; $display("FAIL txe_order got=%h %h %h want=10 20 30", st_dat[0], st_dat[1], st_dat[2]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] fill [$];
    int errs = 0;
    ft2_txe_n = 1'b1;
    tick(6);
    clr();
    for (int i = 0; i < 16; i++) fill.push_back(8'(i * 7 + 1));
    push_bytes(fill);
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_full_level got=%0d want=16", fifo_level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovf_in_ready got=%b want=0", in_ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
    push_bytes('{8'hEE});
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d want=16", fifo_level); end
    ft2_txe_n = 1'b0;
    wait_lens(16, 180);
    tick(30);
    total++; if (st_len.size() !== 16) begin bad++; $display("FAIL ovf_drain_count got=%0d want=16", st_len.size()); end
    if (st_dat.size() == 16)
      foreach (fill[i]) if (st_dat[i] !== fill[i]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL ovf_drain_data got=%0d bad bytes want=0", errs); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL ovf_drain_level got=%0d want=0", fifo_level); end
  endtask

  task automatic test_grant();
    int oe_seen = 0;
    int k = 0;
    gnt_follow = 1'b0;
    gnt_force  = 1'b0;
    ft2_txe_n  = 1'b0;
    clr();
    push_bytes('{8'h5A});
    while (!ft2_bus_req && k < 10) begin @(negedge clk); k++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ft2_data_oe) oe_seen++;
    end
    total++; if (ft2_bus_req !== 1'b1) begin bad++; $display("FAIL gnt_req_held got=%b want=1", ft2_bus_req); end
    total++; if (oe_seen !== 0) begin bad++; $display("FAIL gnt_no_oe got=%0d want=0", oe_seen); end
    total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL gnt_no_pop got=%0d want=1", fifo_level); end
    ft2_txe_n = 1'b1;
    tick(4);
    total++; if (ft2_bus_req !== 1'b0) begin bad++; $display("FAIL gnt_req_drop got=%b want=0", ft2_bus_req); end
    total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL gnt_drop_level got=%0d want=1", fifo_level); end
    ft2_txe_n = 1'b0;
    k = 0;
    while (!ft2_bus_req && k < 10) begin @(negedge clk); k++; end
    tick(2);
    gnt_force = 1'b1;
    wait_lens(1, 20);
    k = 0;
    while (ft2_bus_req && k < 20) begin @(negedge clk); k++; end
    gnt_force = 1'b0;
    total++; if (st_dat.size() !== 1) begin bad++; $display("FAIL gnt_write_count got=%0d want=1", st_dat.size()); end
    else begin
      total++; if (st_dat[0] !== 8'h5A) begin bad++; $display("FAIL gnt_write_data got=%h want=5a", st_dat[0]); end
    end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL gnt_final_level got=%0d want=0", fifo_level); end
    gnt_follow = 1'b1;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    ft2_txe_n  = 1'b0;
    gnt_follow = 1'b1;
    tick(4);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL mid_ovf_sticky got=%b want=1", overflow); end
    push_bytes('{8'h77, 8'h88});
    while (ft2_wr_n && k < 30) begin @(negedge clk); k++; end
    total++; if (ft2_wr_n !== 1'b0) begin bad++; $display("FAIL mid_strobe_seen got=%b want=0", ft2_wr_n); end
    #1 rst = 1'b1;
    #1;
    total++; if (ft2_wr_n !== 1'b1) begin bad++; $display("FAIL mid_wr_n got=%b want=1", ft2_wr_n); end
    total++; if (ft2_data_oe !== 1'b0) begin bad++; $display("FAIL mid_oe got=%b want=0", ft2_data_oe); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b want=0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clr();
    tick(20);
    total++; if (st_dat.size() !== 0) begin bad++; $display("FAIL mid_no_retry got=%0d want=0", st_dat.size()); end
    push_bytes('{8'h99});
    wait_lens(1, 30);
    total++; if (st_len.size() !== 1) begin bad++; $display("FAIL mid_after_count got=%0d want=1", st_len.size()); end
    else begin
      total++; if (st_dat[0] !== 8'h99) begin bad++; $display("FAIL mid_after_data got=%h want=99", st_dat[0]); end
      total++; if (st_len[0] !== 2) begin bad++; $display("FAIL mid_after_len got=%0d want=2", st_len[0]); end
    end
    tick(8);
  endtask

`ifdef FT2_TX_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (tx_count !== 16'd0) begin bad++; $display("FAIL stats_reset got=%0d want=0", tx_count); end
    tick(3);
    clr();
    push_bytes('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    wait_lens(5, 80);
    tick(2);
    total++; if (tx_count !== 16'd5) begin bad++; $display("FAIL stats_count got=%0d want=5", tx_count); end
  endtask
`endif

  task automatic test_bus_rules();
    total++; if (stab_err !== 0) begin bad++; $display("FAIL rules_data_stable got=%0d want=0", stab_err); end
    total++; if (bus_viol !== 0) begin bad++; $display("FAIL rules_drive_without_grant got=%0d want=0", bus_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_txe_block();
    test_overflow();
    test_grant();
    test_reset_mid();
`ifdef FT2_TX_STATS_EN
    test_stats();
`endif
    test_bus_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
